// File: rtl/fp_regfile_wb.sv
// FP register file, condition-code register and fixed-latency writeback scoreboard for coprocessor 1.
// Optional macro FP_BYPASS_EN forwards writeback data/CC to reads and the hazard check.
module fp_regfile_wb #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_fs,
    input  logic [4:0]  issue_ft,
    input  logic [4:0]  issue_fd,
    input  logic        issue_wr,
    input  logic        issue_cc,
    output logic [31:0] din1,
    output logic [31:0] din2,
    input  logic [31:0] res_data,
    input  logic        res_cc,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        cc_out,
    output logic        cc_pending,
    output logic        busy
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic       cc;
        logic [4:0] fd;
    } stage_t;

    logic [31:0]       regs_q [32];
    logic              cc_q, cc_d;
    logic [31:0]       pend_q, pend_d;
    logic              ccp_q, ccp_d;
    stage_t [LAT-1:0]  pipe_q, pipe_d;

    stage_t            wb, ins;
    logic              wb_wr, wb_cc, accept;
    logic [31:0]       wb_mask, set_mask, pend_eff;
    logic              ccp_eff;
    logic [LAT-1:0]    vbits;

    assign wb      = pipe_q[LAT-1];
    assign wb_wr   = wb.v & wb.wr;
    assign wb_cc   = wb.v & wb.cc;
    assign wb_mask = wb_wr ? (32'd1 << wb.fd) : '0;

`ifdef FP_BYPASS_EN
    // The register being written back this cycle is already resolved.
    assign pend_eff = pend_q & ~wb_mask;
    assign ccp_eff  = ccp_q & ~wb_cc;
    assign din1     = (wb_wr && wb.fd == issue_fs) ? res_data : regs_q[issue_fs];
    assign din2     = (wb_wr && wb.fd == issue_ft) ? res_data : regs_q[issue_ft];
    assign rd_data  = (wb_wr && wb.fd == rd_addr)  ? res_data : regs_q[rd_addr];
    assign cc_out   = wb_cc ? res_cc : cc_q;
`else
    assign pend_eff = pend_q;
    assign ccp_eff  = ccp_q;
    assign din1     = regs_q[issue_fs];
    assign din2     = regs_q[issue_ft];
    assign rd_data  = regs_q[rd_addr];
    assign cc_out   = cc_q;
`endif

    assign issue_ready = !(pend_eff[issue_fs] | pend_eff[issue_ft] |
                           (issue_wr & pend_eff[issue_fd]) | (issue_cc & ccp_eff));
    assign accept      = issue_valid & issue_ready;
    assign ins         = '{v: accept, wr: issue_wr, cc: issue_cc, fd: issue_fd};
    assign set_mask    = (accept & issue_wr) ? (32'd1 << issue_fd) : '0;

    generate
        if (LAT > 1) begin : g_shift
            assign pipe_d = {pipe_q[LAT-2:0], ins};
        end else begin : g_single
            assign pipe_d = ins;
        end
        for (genvar g = 0; g < LAT; g++) begin : g_valid
            assign vbits[g] = pipe_q[g].v;
        end
    endgenerate

    assign busy       = |vbits;
    assign cc_pending = ccp_q;

    // Clear before set so a same-cycle re-issue to the retiring register stays pending.
    always_comb begin
        pend_d = (pend_q & ~wb_mask) | set_mask;
        ccp_d  = (ccp_q & ~wb_cc) | (accept & issue_cc);
        cc_d   = wb_cc ? res_cc : cc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            cc_q   <= 1'b0;
            pend_q <= '0;
            ccp_q  <= 1'b0;
            pipe_q <= '0;
        end else begin
            if (wb_wr) begin
                regs_q[wb.fd] <= res_data;
            end
            cc_q   <= cc_d;
            pend_q <= pend_d;
            ccp_q  <= ccp_d;
            pipe_q <= pipe_d;
        end
    end

endmodule

// File: tb/tb_fp_regfile_wb.sv
// Directed bench for fp_regfile_wb (LAT=2, default build without FP_BYPASS_EN).
module tb_fp_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_fs, issue_ft, issue_fd, rd_addr;
    logic        issue_wr, issue_cc, res_cc;
    logic [31:0] din1, din2, res_data, rd_data;
    logic        cc_out, cc_pending, busy;

    int checks = 0;
    int errors = 0;

    fp_regfile_wb #(.LAT(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .issue_wr(issue_wr), .issue_cc(issue_cc),
        .din1(din1), .din2(din2),
        .res_data(res_data), .res_cc(res_cc),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cc_out(cc_out), .cc_pending(cc_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rst, v, wr, cc, fs, ft, fd, ra, res, rcc, chk;
        logic [31:0] ready, d1, d2, rd, bsy, cco, ccp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] v, input logic [31:0] fs, input logic [31:0] ft,
                         input logic [31:0] fd, input logic [31:0] wr, input logic [31:0] cc,
                         input logic [31:0] res, input logic [31:0] rcc, input logic [31:0] ra);
        issue_valid = v[0];
        issue_fs    = fs[4:0];
        issue_ft    = ft[4:0];
        issue_fd    = fd[4:0];
        issue_wr    = wr[0];
        issue_cc    = cc[0];
        res_data    = res;
        res_cc      = rcc[0];
        rd_addr     = ra[4:0];
        #1;
    endtask

    task automatic idle(input logic [31:0] res, input logic [31:0] rcc, input logic [31:0] ra);
        drive(0, 0, 0, 0, 0, 0, res, rcc, ra);
    endtask

    initial begin
        //           rst v wr cc fs ft fd ra res            rcc chk rdy din1          din2          rd_data       bsy cco ccp
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,             0,  0,  1,  0,            0,            0,            0,  0,  0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 3, 0,             0,  1,  1,  0,            0,            0,            0,  0,  0};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 3, 3, 0,             0,  1,  1,  0,            0,            0,            0,  0,  0};
        vecs[3]  = '{0, 0, 0, 0, 3, 0, 0, 3, 0,             0,  1,  0,  0,            0,            0,            1,  0,  0};
        vecs[4]  = '{0, 0, 0, 0, 3, 0, 0, 3, 32'h3F800000,  0,  1,  0,  0,            0,            0,            1,  0,  0};
        vecs[5]  = '{0, 0, 0, 0, 3, 0, 0, 3, 0,             0,  1,  1,  32'h3F800000, 0,            32'h3F800000, 0,  0,  0};
        vecs[6]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0,             0,  1,  1,  0,            0,            0,            0,  0,  0};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 2, 0, 0,             0,  1,  1,  0,            0,            0,            1,  0,  0};
        vecs[8]  = '{0, 1, 1, 0, 0, 0, 3, 0, 32'h11111111,  0,  1,  1,  0,            0,            0,            1,  0,  0};
        vecs[9]  = '{0, 1, 1, 0, 0, 0, 4, 1, 32'h22222222,  0,  1,  1,  0,            0,            32'h11111111, 1,  0,  0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 2, 32'h33333333,  0,  1,  1,  0,            0,            32'h22222222, 1,  0,  0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 3, 32'h44444444,  0,  1,  1,  0,            0,            32'h33333333, 1,  0,  0};
        vecs[12] = '{0, 0, 0, 0, 1, 2, 0, 4, 0,             0,  1,  1,  32'h11111111, 32'h22222222, 32'h44444444, 0,  0,  0};
        vecs[13] = '{0, 1, 0, 0, 0, 0, 5, 5, 0,             0,  1,  1,  0,            0,            0,            0,  0,  0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 5, 0,             0,  1,  1,  0,            0,            0,            1,  0,  0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 5, 32'h00000BAD,  1,  1,  1,  0,            0,            0,            1,  0,  0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 5, 0,             0,  1,  1,  0,            0,            0,            0,  0,  0};

        rst = 1'b1;
        idle(0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst[0];
            drive(vecs[i].v, vecs[i].fs, vecs[i].ft, vecs[i].fd, vecs[i].wr, vecs[i].cc,
                  vecs[i].res, vecs[i].rcc, vecs[i].ra);
            if (vecs[i].chk[0]) begin
                check($sformatf("vec%0d issue_ready", i), {31'b0, issue_ready}, vecs[i].ready);
                check($sformatf("vec%0d din1", i), din1, vecs[i].d1);
                check($sformatf("vec%0d din2", i), din2, vecs[i].d2);
                check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rd);
                check($sformatf("vec%0d busy", i), {31'b0, busy}, vecs[i].bsy);
                check($sformatf("vec%0d cc_out", i), {31'b0, cc_out}, vecs[i].cco);
                check($sformatf("vec%0d cc_pending", i), {31'b0, cc_pending}, vecs[i].ccp);
            end
            tick();
        end

        // RAW: add.s f5 = f1 + f2, then an op reading f5 stalls until C+3.
        drive(1, 1, 2, 5, 1, 0, 0, 0, 0);
        check("raw first accept", {31'b0, issue_ready}, 1);
        tick();
        drive(1, 5, 0, 6, 1, 0, 0, 0, 0);
        check("raw stall C+1", {31'b0, issue_ready}, 0);
        tick();
        drive(1, 5, 0, 6, 1, 0, 32'h55555555, 0, 0);
        check("raw stall C+2", {31'b0, issue_ready}, 0);
        tick();
        drive(1, 5, 0, 6, 1, 0, 0, 0, 0);
        check("raw accept C+3", {31'b0, issue_ready}, 1);
        check("raw din1 C+3", din1, 32'h55555555);
        tick();
        idle(0, 0, 6);
        tick();
        idle(32'h66666666, 0, 6);
        tick();
        idle(0, 0, 6);
        check("raw dependent result", rd_data, 32'h66666666);
        check("raw busy clear", {31'b0, busy}, 0);

        // CC hazard: second compare waits for the first CC writeback.
        drive(1, 1, 2, 0, 0, 1, 0, 0, 0);
        check("cc first accept", {31'b0, issue_ready}, 1);
        tick();
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0);
        check("cc non-cc op unblocked", {31'b0, issue_ready}, 1);
        issue_valid = 1'b0;
        issue_cc    = 1'b1;
        #1;
        check("cc stall C+1", {31'b0, issue_ready}, 0);
        check("cc pending C+1", {31'b0, cc_pending}, 1);
        tick();
        drive(1, 1, 2, 0, 0, 1, 0, 1, 0);
        check("cc stall C+2", {31'b0, issue_ready}, 0);
        check("cc_out before wb", {31'b0, cc_out}, 0);
        tick();
        drive(1, 1, 2, 0, 0, 1, 0, 0, 0);
        check("cc accept C+3", {31'b0, issue_ready}, 1);
        check("cc_out after wb", {31'b0, cc_out}, 1);
        check("cc pending after wb", {31'b0, cc_pending}, 0);
        tick();
        idle(0, 0, 0);
        check("cc pending second", {31'b0, cc_pending}, 1);
        check("cc_out held", {31'b0, cc_out}, 1);
        tick();
        idle(0, 0, 0);
        tick();
        idle(0, 0, 0);
        check("cc_out second result", {31'b0, cc_out}, 0);
        check("cc pending cleared", {31'b0, cc_pending}, 0);

        // Reset one cycle after issuing f7: in-flight write discarded.
        drive(1, 0, 0, 7, 1, 0, 0, 0, 7);
        tick();
        rst = 1'b1;
        idle(0, 0, 7);
        tick();
        rst = 1'b0;
        drive(0, 7, 7, 7, 1, 0, 32'hDEADBEEF, 1, 7);
        check("rst busy", {31'b0, busy}, 0);
        check("rst f7 not pending", {31'b0, issue_ready}, 1);
        check("rst cc_pending", {31'b0, cc_pending}, 0);
        tick();
        idle(0, 0, 7);
        check("rst f7 reads 0", rd_data, 0);
        check("rst f3 cleared", {31'b0, busy}, 0);
        rd_addr = 5'd3;
        #1;
        check("rst f3 reads 0", rd_data, 0);
        check("rst cc_out", {31'b0, cc_out}, 0);

        // WAW on f9: second write stalls, final value is the second result.
        drive(1, 0, 0, 9, 1, 0, 0, 0, 9);
        check("waw first accept", {31'b0, issue_ready}, 1);
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 9);
        check("waw stall C+1", {31'b0, issue_ready}, 0);
        tick();
        drive(1, 0, 0, 9, 1, 0, 32'h99999991, 0, 9);
        check("waw stall C+2", {31'b0, issue_ready}, 0);
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 9);
        check("waw accept C+3", {31'b0, issue_ready}, 1);
        tick();
        idle(0, 0, 9);
        check("waw first value", rd_data, 32'h99999991);
        check("waw busy", {31'b0, busy}, 1);
        tick();
        idle(32'h99999992, 0, 9);
        tick();
        idle(0, 0, 9);
        check("waw final value", rd_data, 32'h99999992);
        check("waw busy clear", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
